alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8..64, even.
REQ-002 Parameter: CNT_W, default 6, iteration-counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 start  input  1  operation request, sampled only when busy=0.
REQ-006 controle  input  4  operation select, latched with start.
REQ-007 r1, r2  input  WIDTH  operands, latched with start.
REQ-008 branch_eq, branch_neq  input  1  compare-mode select, latched with start.
REQ-009 result  output  WIDTH  registered result; holds until the next done.
REQ-010 zero  output  1  registered branch-taken flag.
REQ-011 hi, lo  output  WIDTH  registered multiply/divide result pair.
REQ-012 busy  output  1  high while an iterative op runs.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 div_by_zero  output  1  set with done on DIVU with r2=0; else cleared with done.

Function
REQ-015 Encodings: 0000 AND; 0001 OR; 0010 ADD (mod 2**WIDTH); 0110 SUB (mod 2**WIDTH); 0111 unsigned less-than (result = 1 or 0, zero-extended); 1100 NOR; 1000 MULTU; 1001 DIVU; 1010 MFHI (result=hi); 1011 MFLO (result=lo); any other code -> result=0.
REQ-016 FSM states IDLE, MUL, DIV; only IDLE accepts start.
REQ-017 Single-cycle ops (all except 1000/1001): start sampled at edge N -> result, zero, done=1 at edge N; busy stays 0; state stays IDLE.
REQ-018 zero at completion: branch_eq=1 -> (r1==r2); else branch_neq=1 -> (r1!=r2); else 0; branch_eq has priority when both are set.
REQ-019 MULTU: start at edge N -> MUL, busy=1; one shift-add iteration per edge N+1..N+WIDTH; at edge N+WIDTH {hi,lo} = r1*r2 (2*WIDTH unsigned), busy=0, done=1, state IDLE.
REQ-020 DIVU (r2!=0): same timing as MULTU via restoring division; lo=quotient, hi=remainder, div_by_zero=0.
REQ-021 DIVU with r2=0: completes as a single-cycle op at edge N; lo=all ones, hi=r1, div_by_zero=1, busy stays 0.
REQ-022 MULTU/DIVU leave result and zero unchanged; single-cycle ops leave hi/lo unchanged.
REQ-023 start while busy=1 is ignored (no queueing, no effect on the running op).
REQ-024 Input changes on r1/r2/controle/branch_* while busy=1 SHALL NOT affect the running op.
REQ-025 done is high for exactly one cycle per accepted op; start at the completing edge is accepted, so back-to-back ops run at full rate.
REQ-026 Arithmetic carries and overflow are discarded; no overflow flag exists.

Reset
REQ-027 reset=1 at an edge: state IDLE, counter 0, result=0, zero=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0.
REQ-028 reset overrides start at the same edge; the request is dropped.
REQ-029 reset during MUL/DIV aborts the op; no done pulse and no hi/lo update follow.

Verification (WIDTH=32)
REQ-030 ADD r1=0xFFFFFFFF, r2=2 -> next edge result=0x00000001, done=1 for one cycle, busy=0.
REQ-031 Branch compare: SUB r1=r2=5 with branch_eq=1 -> zero=1; same operands with branch_neq=1 -> zero=0; both flags set -> zero=1.
REQ-032 MULTU r1=0xFFFFFFFF, r2=0xFFFFFFFF -> busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse; r1/r2 toggled mid-op and a second start during busy have no effect.
REQ-033 DIVU r1=100, r2=7 -> after 32 cycles lo=14, hi=2, div_by_zero=0; then DIVU r2=0, r1=9 -> next edge lo=0xFFFFFFFF, hi=9, div_by_zero=1.
REQ-034 Start MULTU, assert reset at iteration 10 -> all outputs 0 and no done pulse follows; a new ADD start then completes normally.
REQ-035 Issue MULTU, then MFLO at the completing edge -> MFLO completes one edge later with result equal to the new lo.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle logic/arithmetic ALU plus iterative unsigned
// multiply (shift-add) and divide (restoring), one iteration per clock.
// hi/lo hold the 2*WIDTH product or the remainder/quotient pair.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       controle,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic             branch_eq,
    input  logic             branch_neq,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    // Working registers shared by both iterative ops:
    // MUL: acc_hi = partial product upper half, acc_lo = multiplier / low half.
    // DIV: acc_hi = partial remainder, acc_lo = dividend shifting into quotient.
    logic [WIDTH-1:0] acc_hi, acc_lo, operand;

    logic             last_iter;
    logic [WIDTH-1:0] alu_result;
    logic             branch_flag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_hi_next, div_lo_next;

    assign last_iter = (cnt == LAST_ITER);

    // Next-state logic and busy flag derived from the current state.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        state_next = state;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start && controle == OP_MULTU)
                    state_next = MUL;
                else if (start && controle == OP_DIVU && r2 != '0)
                    state_next = DIV;
            end
            MUL, DIV: begin
                if (last_iter)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle ALU result and branch compare on the live operands.
    always_comb begin
        alu_result = '0;
        unique case (controle)
            OP_AND:  alu_result = r1 & r2;
            OP_OR:   alu_result = r1 | r2;
            OP_ADD:  alu_result = r1 + r2;
            OP_SUB:  alu_result = r1 - r2;
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (r1 < r2)};
            OP_NOR:  alu_result = ~(r1 | r2);
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = '0;
        endcase
        if (branch_eq)
            branch_flag = (r1 == r2);
        else if (branch_neq)
            branch_flag = (r1 != r2);
        else
            branch_flag = 1'b0;
    end

    // One shift-add and one restoring-divide step on the working registers.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};

        // Partial remainder stays below the divisor, so WIDTH+1 bits suffice.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (!div_diff[WIDTH]) begin
            div_hi_next = div_diff[WIDTH-1:0];
            div_lo_next = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_next = div_shift[WIDTH-1:0];
            div_lo_next = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples values from before the edge, independent of statement order.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Datapath: operand capture, iteration, and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            operand     <= '0;
            result      <= '0;
            zero        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (controle == OP_MULTU ||
                            (controle == OP_DIVU && r2 != '0)) begin
                            acc_hi  <= '0;
                            acc_lo  <= r1;
                            operand <= r2;
                            cnt     <= '0;
                        end else if (controle == OP_DIVU) begin
                            // Divide by zero finishes immediately.
                            lo          <= '1;
                            hi          <= r1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            result      <= alu_result;
                            zero        <= branch_flag;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_next;
                    acc_lo <= mul_lo_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        hi          <= mul_hi_next;
                        lo          <= mul_lo_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DIV: begin
                    acc_hi <= div_hi_next;
                    acc_lo <= div_lo_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        hi          <= div_hi_next;
                        lo          <= div_lo_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed scenarios plus
// randomized operations against a plain-arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, branch_eq, branch_neq;
    logic [3:0]   controle;
    logic [W-1:0] r1, r2;
    logic [W-1:0] result, hi, lo;
    logic         zero, busy, done, div_by_zero;

    alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .controle(controle),
        .r1(r1), .r2(r2), .branch_eq(branch_eq), .branch_neq(branch_neq),
        .result(result), .zero(zero), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    logic [W-1:0] exp_result, exp_hi, exp_lo;
    logic         exp_zero, exp_dbz;

    // Apply one accepted operation to the model using plain arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic be, input logic bn);
        logic [2*W-1:0] p;
        case (op)
            4'b1000: begin
                p = (2*W)'(a) * (2*W)'(b);
                exp_hi = p[2*W-1:W];
                exp_lo = p[W-1:0];
                exp_dbz = 1'b0;
            end
            4'b1001: begin
                if (b == 0) begin
                    exp_lo = {W{1'b1}};
                    exp_hi = a;
                    exp_dbz = 1'b1;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                    exp_dbz = 1'b0;
                end
            end
            default: begin
                case (op)
                    4'b0000: exp_result = a & b;
                    4'b0001: exp_result = a | b;
                    4'b0010: exp_result = a + b;
                    4'b0110: exp_result = a - b;
                    4'b0111: exp_result = (a < b) ? 1 : 0;
                    4'b1100: exp_result = ~(a | b);
                    4'b1010: exp_result = exp_hi;
                    4'b1011: exp_result = exp_lo;
                    default: exp_result = 0;
                endcase
                exp_zero = be ? (a == b) : (bn ? (a != b) : 1'b0);
                exp_dbz = 1'b0;
            end
        endcase
    endtask

    // Issue one op from a negedge; return at the negedge where done is seen.
    // With disturb set, inputs and start are scrambled while the op is busy.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic be, input logic bn,
                          input bit disturb, output int busy_cycles);
        int guard;
        model_op(op, a, b, be, bn);
        controle = op; r1 = a; r2 = b; branch_eq = be; branch_neq = bn;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (!done) begin
            if (busy) busy_cycles++;
            guard++;
            if (guard > 3 * W) begin
                n_cmp++; n_mis++;
                $display("FAIL timeout op=%b: done never seen within %0d cycles", op, 3 * W);
                break;
            end
            if (disturb) begin
                r1 = $urandom; r2 = $urandom; controle = 4'($urandom);
                branch_eq = 1'($urandom); branch_neq = 1'($urandom);
                start = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        // A start at a reset edge must be dropped.
        start = 1'b1; controle = 4'b0010; r1 = 32'd3; r2 = 32'd4;
        branch_eq = 1'b1; branch_neq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        n_cmp++;
        if ({result, hi, lo} !== '0 || {zero, busy, done, div_by_zero} !== 4'b0) begin
            n_mis++;
            $display("FAIL reset_state: result=%h hi=%h lo=%h z/b/d/dbz=%b, required all 0",
                     result, hi, lo, {zero, busy, done, div_by_zero});
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || result !== '0) begin
            n_mis++;
            $display("FAIL reset_drops_start: done=%b result=%h, required 0/0", done, result);
        end
        exp_result = '0; exp_hi = '0; exp_lo = '0; exp_zero = 1'b0; exp_dbz = 1'b0;
    endtask

    task automatic test_add_wrap;
        int bc;
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, bc);
        n_cmp++;
        if (result !== 32'h0000_0001 || busy !== 1'b0 || bc != 0) begin
            n_mis++;
            $display("FAIL add_wrap: result=%h busy=%b busy_cycles=%0d, required 00000001/0/0",
                     result, busy, bc);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_mis++;
            $display("FAIL add_done_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_branch;
        int bc;
        logic [2:0] flags [3] = '{3'b101, 3'b010, 3'b111};  // {be, bn, expected zero}
        for (int i = 0; i < 3; i++) begin
            run_op(4'b0110, 32'd5, 32'd5, flags[i][2], flags[i][1], 1'b0, bc);
            n_cmp++;
            if (zero !== flags[i][0] || result !== 32'd0) begin
                n_mis++;
                $display("FAIL branch_%0d: zero=%b result=%h, required zero=%b result=0",
                         i, zero, result, flags[i][0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_multu;
        int bc;
        run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, bc);
        n_cmp++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || bc != W) begin
            n_mis++;
            $display("FAIL multu_max: hi=%h lo=%h busy_cycles=%0d, required FFFFFFFE/00000001/%0d",
                     hi, lo, bc, W);
        end
        n_cmp++;
        if (result !== exp_result || zero !== exp_zero || busy !== 1'b0 || div_by_zero !== 1'b0) begin
            n_mis++;
            $display("FAIL multu_side: result=%h zero=%b busy=%b dbz=%b, required %h/%b/0/0",
                     result, zero, busy, div_by_zero, exp_result, exp_zero);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== exp_hi) begin
            n_mis++;
            $display("FAIL multu_after: done=%b busy=%b hi=%h, required 0/0/%h", done, busy, hi, exp_hi);
        end
    endtask

    task automatic test_divu;
        int bc;
        run_op(4'b1001, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, bc);
        n_cmp++;
        if (lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0 || bc != W) begin
            n_mis++;
            $display("FAIL divu_100_7: lo=%0d hi=%0d dbz=%b busy_cycles=%0d, required 14/2/0/%0d",
                     lo, hi, div_by_zero, bc, W);
        end
        @(negedge clk);
        run_op(4'b1001, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, bc);
        n_cmp++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'd9 || div_by_zero !== 1'b1 || bc != 0 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL divu_by_zero: lo=%h hi=%h dbz=%b busy_cycles=%0d, required FFFFFFFF/9/1/0",
                     lo, hi, div_by_zero, bc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int seen_done;
        int bc;
        controle = 4'b1000; r1 = 32'h1234_5678; r2 = 32'h9ABC_DEF0;
        branch_eq = 1'b0; branch_neq = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_result = '0; exp_hi = '0; exp_lo = '0; exp_zero = 1'b0; exp_dbz = 1'b0;
        n_cmp++;
        if ({result, hi, lo} !== '0 || {zero, busy, done, div_by_zero} !== 4'b0) begin
            n_mis++;
            $display("FAIL abort_state: result=%h hi=%h lo=%h z/b/d/dbz=%b, required all 0",
                     result, hi, lo, {zero, busy, done, div_by_zero});
        end
        seen_done = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0 || hi !== '0 || lo !== '0) begin
            n_mis++;
            $display("FAIL abort_no_done: done/busy cycles=%0d hi=%h lo=%h, required 0/0/0",
                     seen_done, hi, lo);
        end
        run_op(4'b0010, 32'd40, 32'd2, 1'b0, 1'b0, 1'b0, bc);
        n_cmp++;
        if (result !== 32'd42) begin
            n_mis++;
            $display("FAIL abort_then_add: result=%0d, required 42", result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int bc;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        run_op(4'b1000, a, b, 1'b0, 1'b0, 1'b0, bc);
        // MFLO issued immediately while done is still high.
        run_op(4'b1011, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, bc);
        n_cmp++;
        if (result !== exp_lo || bc != 0) begin
            n_mis++;
            $display("FAIL mflo_after_multu: result=%h busy_cycles=%0d, required %h/0", result, bc, exp_lo);
        end
        // Full-rate stream of single-cycle ops with start held high.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            model_op(4'b0010, a, b, 1'b0, 1'b0);
            controle = 4'b0010; r1 = a; r2 = b; branch_eq = 1'b0; branch_neq = 1'b0;
            start = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b1 || result !== exp_result) begin
                n_mis++;
                $display("FAIL stream_%0d: done=%b result=%h, required 1/%h", i, done, result, exp_result);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int bc;
        logic [3:0] ops [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                                 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0011, 4'b1101,
                                 4'b1001, 4'b1000, 4'b0111, 4'b1111};
        logic [3:0]   op;
        logic [W-1:0] a, b;
        int           exp_bc;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 15)];
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = a;
                2: b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            exp_bc = (op == 4'b1000 || (op == 4'b1001 && b != 0)) ? W : 0;
            run_op(op, a, b, 1'($urandom), 1'($urandom), 1'(i % 2), bc);
            n_cmp++;
            if (result !== exp_result || zero !== exp_zero || hi !== exp_hi || lo !== exp_lo ||
                div_by_zero !== exp_dbz || bc != exp_bc || busy !== 1'b0) begin
                n_mis++;
                $display("FAIL random_%0d op=%b a=%h b=%h: got res=%h z=%b hi=%h lo=%h dbz=%b bc=%0d, required res=%h z=%b hi=%h lo=%h dbz=%b bc=%0d",
                         i, op, a, b, result, zero, hi, lo, div_by_zero, bc,
                         exp_result, exp_zero, exp_hi, exp_lo, exp_dbz, exp_bc);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; controle = '0; r1 = '0; r2 = '0;
        branch_eq = 1'b0; branch_neq = 1'b0;
        @(negedge clk);
        test_reset;
        test_add_wrap;
        test_branch;
        test_multu;
        test_divu;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
